spi_ctrl: RTL and testbench
===========================

Name: spi_ctrl

Overview:
- Initiator (master) side of the team's single-wire-each-way SPI memory link. It is the opposite end of the spi_mem responder.
- Converts parallel write/read requests from a bench or host FSM into the cs/serial frame that spi_mem expects.
- Collects read data returned after the responder's ready pulse.
- Reports completion on done/dout once the responder's op_done arrives.

Parameters:
- TIMEOUT, 32, max cycles spent in WAIT_READY or WAIT_DONE before abort (used only with SPI_CTRL_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- wr  input  1  1 = write, 0 = read; latched with start.
- addr  input  8  memory address; latched with start.
- din  input  8  write data; latched with start.
- cs  output  1  chip select to responder, active low.
- miso  output  1  serial data to the responder's miso input.
- mosi  input  1  serial read data from the responder.
- ready  input  1  responder pulse: read data follows.
- op_done  input  1  responder completion pulse.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- dout  output  8  read data; updated on a read's done, held otherwise.
- err  output  1  one-cycle abort pulse, coincident with done.

Behaviour:
- Reset (async): state=IDLE, cs=1, miso=0, busy=0, done=0, dout=0x00, err=0, counters=0.
- States: IDLE, SETUP, CMD, SHIFT_TX, WAIT_READY, SHIFT_RX, WAIT_DONE.
- Frame: bits are sent LSB first, one per clock.
  - Write frame: 16 bits = {din, addr}, so addr[0] goes first.
  - Read frame: 8 bits = addr.
- Edge numbering: E0 is the edge that samples start=1 in IDLE; E1, E2, … are the following edges.
- IDLE, start=1 at E0:
  - Latch wr/addr/din.
  - cs<=0, miso<=wr, busy<=1.
  - Go to SETUP.
- SETUP (E1): hold cs=0 and miso=wr; go to CMD. The responder samples the command bit at E2.
- CMD (E2): miso<=frame[0], cnt<=1; go to SHIFT_TX.
- SHIFT_TX:
  - While cnt<N: miso<=frame[cnt], cnt++.
  - When cnt==N: cs<=1, miso<=0.
  - Write (N=16): cs rises at E18; go to WAIT_DONE.
  - Read (N=8): cs rises at E10; go to WAIT_READY.
- cs must rise before the responder returns to idle, otherwise the responder re-triggers.
- WAIT_READY: on ready=1, cnt<=0 and go to SHIFT_RX. For reads, ready is first seen at E12.
- SHIFT_RX:
  - Each edge: rx[cnt]<=mosi, cnt++.
  - After 8 samples (E13..E20 for reads), go to WAIT_DONE.
- WAIT_DONE: on op_done=1:
  - done<=1 for one cycle.
  - dout<=rx if read.
  - busy<=0; go to IDLE.
- Latency from E0 to done high:
  - Write: done high after E20 (20 cycles).
  - Read: done high after E21 (21 cycles).
- start while busy is ignored, with no queueing.
- start and done in the same cycle: start is ignored, because the state is not IDLE.
- ready or op_done arriving in any other state is ignored.
- Reset mid-transfer: immediate IDLE with cs=1. The partial frame is discarded and dout is cleared to 0x00.

Optional Feature:
- Macro: SPI_CTRL_TIMEOUT_EN.
- When defined:
  - A wait counter clears on entry to WAIT_READY and WAIT_DONE and increments each cycle in those states.
  - Reaching TIMEOUT forces cs=1 and pulses done=1 and err=1 together.
  - dout is unchanged; busy<=0; state goes to IDLE.
- When undefined: the block waits indefinitely, err is tied to 0, and no counter is built.

Test Plan:
- Write addr=0x05, din=0xA5 to spi_mem:
  - miso shows 1,1 (command), then LSB-first 0x05 then 0xA5.
  - cs is low from after E0 until E18.
  - done pulses after E20; err=0.
- Read addr=0x05 after the write above:
  - cs low for 10 cycles; ready is seen, 8 bits are captured.
  - done after E21 with dout=0xA5.
- Read addr=0x03 (never written): dout=0x00, done after E21.
- start pulsed at E5 during a write: no effect. Frame and done timing are identical to the write scenario, and busy stays 1.
- Assert rst at E8 of a write: cs=1, busy=0, done=0 immediately. The next write after release completes normally.
- With SPI_CTRL_TIMEOUT_EN, TIMEOUT=32, and the responder held in reset during a read:
  - done=1 and err=1 at exactly 32 cycles after WAIT_READY entry.
  - dout is unchanged and cs=1.

Source files
------------

// File: rtl/spi_ctrl.sv
// rtl/spi_ctrl.sv - SPI memory-link initiator: serialises write/read requests, collects read data.
// Optional wait-state abort is built only when SPI_CTRL_TIMEOUT_EN is defined.
module spi_ctrl #(
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic       cs,
    output logic       miso,
    input  logic       mosi,
    input  logic       ready,
    input  logic       op_done,
    output logic       busy,
    output logic       done,
    output logic [7:0] dout,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CMD,
        SHIFT_TX,
        WAIT_READY,
        SHIFT_RX,
        WAIT_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [15:0] frame_q, frame_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        cs_q, cs_d;
    logic        miso_q, miso_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  rx_q, rx_d;
    logic        timeout_hit;

`ifdef SPI_CTRL_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    // Every non-wait state clears the counter, so entry into a wait state starts from zero.
    assign timeout_hit = (wait_q == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        wait_d = '0;
        err_d  = 1'b0;
        if (state_q == WAIT_READY || state_q == WAIT_DONE) begin
            wait_d = wait_q + 1'b1;
        end
        if (state_q == WAIT_READY && !ready && timeout_hit) begin
            err_d = 1'b1;
        end
        if (state_q == WAIT_DONE && !op_done && timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    // Constant low: without the counter there is no abort path.
    assign err = (TIMEOUT < 0);
`endif

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        miso_d  = miso_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        rx_d    = rx_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    wr_d    = wr;
                    frame_d = {din, addr};
                    cnt_d   = 5'd0;
                    cs_d    = 1'b0;
                    miso_d  = wr;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = CMD;
            end
            CMD: begin
                miso_d  = frame_q[0];
                cnt_d   = 5'd1;
                state_d = SHIFT_TX;
            end
            SHIFT_TX: begin
                if (cnt_q == (wr_q ? 5'd16 : 5'd8)) begin
                    // Release cs before the responder goes idle so it cannot re-trigger.
                    cs_d    = 1'b1;
                    miso_d  = 1'b0;
                    state_d = wr_q ? WAIT_DONE : WAIT_READY;
                end else begin
                    miso_d = frame_q[cnt_q[3:0]];
                    cnt_d  = cnt_q + 5'd1;
                end
            end
            WAIT_READY: begin
                if (ready) begin
                    cnt_d   = 5'd0;
                    state_d = SHIFT_RX;
                end else if (timeout_hit) begin
                    cs_d    = 1'b1;
                    miso_d  = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            SHIFT_RX: begin
                rx_d[cnt_q[2:0]] = mosi;
                cnt_d            = cnt_q + 5'd1;
                if (cnt_q == 5'd7) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (op_done) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (!wr_q) begin
                        dout_d = rx_q;
                    end
                end else if (timeout_hit) begin
                    cs_d    = 1'b1;
                    miso_d  = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            frame_q <= 16'h0000;
            cnt_q   <= 5'd0;
            cs_q    <= 1'b1;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= 8'h00;
            rx_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            miso_q  <= miso_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            rx_q    <= rx_d;
        end
    end

    assign cs   = cs_q;
    assign miso = miso_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_spi_ctrl.sv
// tb/tb_spi_ctrl.sv - directed bench for spi_ctrl with a cycle-scripted spi_mem responder.
module tb_spi_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, wr, mosi, ready, op_done;
    logic [7:0] addr, din;
    logic       cs, miso, busy, done, err;
    logic [7:0] dout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:255];

    // Outputs recorded half a cycle after edge Ek, index k.
    logic       obs_cs   [0:63];
    logic       obs_miso [0:63];
    logic       obs_busy [0:63];
    logic       obs_done [0:63];
    logic       obs_err  [0:63];
    logic [7:0] obs_dout [0:63];
    int         obs_n;

    spi_ctrl #(.TIMEOUT(32)) dut (
        .clk(clk), .rst(rst), .start(start), .wr(wr), .addr(addr), .din(din),
        .cs(cs), .miso(miso), .mosi(mosi), .ready(ready), .op_done(op_done),
        .busy(busy), .done(done), .dout(dout), .err(err)
    );

    always #5 clk = ~clk;

    // Drives one request starting at a negedge; start is sampled at E0. The responder
    // raises ready for E12, returns mem[a] LSB first on E13..E20 and op_done at E20 (write) / E21 (read).
    task automatic drive_op(input logic w, input logic [7:0] a, input logic [7:0] d,
                            input int stray_start, input bit respond, input int nedges);
        logic [7:0] rdata;
        rdata = mem[a];
        wr = w; addr = a; din = d; start = 1'b1;
        obs_n = nedges;
        for (int k = 0; k < nedges; k++) begin
            @(posedge clk);
            @(negedge clk);
            obs_cs[k] = cs; obs_miso[k] = miso; obs_busy[k] = busy;
            obs_done[k] = done; obs_err[k] = err; obs_dout[k] = dout;
            start   = (k + 1 == stray_start);
            if (k + 1 == stray_start) begin
                wr = ~w; addr = ~a; din = ~d;
            end
            ready   = respond && !w && (k + 1 == 12);
            mosi    = (respond && !w && k + 1 >= 13 && k + 1 <= 20) ? rdata[k - 12] : 1'b0;
            op_done = respond && (k + 1 == (w ? 20 : 21));
        end
        start = 1'b0; ready = 1'b0; mosi = 1'b0; op_done = 1'b0;
    endtask

    function automatic int first_cs_high();
        for (int k = 0; k < obs_n; k++) if (obs_cs[k]) return k;
        return -1;
    endfunction

    function automatic int first_done();
        for (int k = 0; k < obs_n; k++) if (obs_done[k]) return k;
        return -1;
    endfunction

    function automatic int done_count();
        int c = 0;
        for (int k = 0; k < obs_n; k++) if (obs_done[k]) c++;
        return c;
    endfunction

    function automatic logic [15:0] tx_bits(input int n);
        logic [15:0] v = 16'h0000;
        for (int i = 0; i < n; i++) v[i] = obs_miso[i + 2];
        return v;
    endfunction

    task automatic test_reset();
        n_checks++;
        if (cs !== 1'b1 || miso !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: cs=%b miso=%b busy=%b, required cs=1 miso=0 busy=0", cs, miso, busy);
        end
        n_checks++;
        if (done !== 1'b0 || err !== 1'b0 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out: done=%b err=%b dout=%h, required 0 0 00", done, err, dout);
        end
    endtask

    task automatic test_write();
        drive_op(1'b1, 8'h05, 8'hA5, -1, 1'b1, 23);
        mem[8'h05] = 8'hA5;
        n_checks++;
        if (obs_miso[0] !== 1'b1 || obs_miso[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL write_cmd: miso E0=%b E1=%b, required 1 1", obs_miso[0], obs_miso[1]);
        end
        n_checks++;
        if (tx_bits(16) !== 16'hA505) begin
            n_fail++;
            $display("FAIL write_frame: got %h, required a505", tx_bits(16));
        end
        n_checks++;
        if (obs_cs[0] !== 1'b0 || obs_cs[17] !== 1'b0 || first_cs_high() != 18) begin
            n_fail++;
            $display("FAIL write_cs: cs high first after E%0d, required E18", first_cs_high());
        end
        n_checks++;
        if (first_done() != 20 || done_count() != 1 || obs_err[20] !== 1'b0) begin
            n_fail++;
            $display("FAIL write_done: done at E%0d count %0d err %b, required E20 1 0",
                     first_done(), done_count(), obs_err[20]);
        end
        n_checks++;
        if (obs_busy[19] !== 1'b1 || obs_busy[20] !== 1'b0 || obs_dout[20] !== 8'h00) begin
            n_fail++;
            $display("FAIL write_busy: busy E19=%b E20=%b dout=%h, required 1 0 00",
                     obs_busy[19], obs_busy[20], obs_dout[20]);
        end
    endtask

    task automatic test_read();
        drive_op(1'b0, 8'h05, 8'h00, -1, 1'b1, 23);
        n_checks++;
        if (obs_miso[0] !== 1'b0 || obs_miso[1] !== 1'b0 || tx_bits(8) !== 16'h0005) begin
            n_fail++;
            $display("FAIL read_frame: cmd %b%b addr %h, required 00 0005", obs_miso[0], obs_miso[1], tx_bits(8));
        end
        n_checks++;
        if (obs_cs[9] !== 1'b0 || first_cs_high() != 10) begin
            n_fail++;
            $display("FAIL read_cs: cs high first after E%0d, required E10", first_cs_high());
        end
        n_checks++;
        if (first_done() != 21 || done_count() != 1) begin
            n_fail++;
            $display("FAIL read_done: done at E%0d count %0d, required E21 1", first_done(), done_count());
        end
        n_checks++;
        if (obs_dout[20] !== 8'h00 || obs_dout[21] !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_dout: E20=%h E21=%h, required 00 a5", obs_dout[20], obs_dout[21]);
        end
    endtask

    task automatic test_read_unwritten();
        drive_op(1'b0, 8'h03, 8'h00, -1, 1'b1, 23);
        n_checks++;
        if (first_done() != 21 || obs_dout[20] !== 8'hA5 || obs_dout[21] !== 8'h00) begin
            n_fail++;
            $display("FAIL read_unwritten: done E%0d dout E20=%h E21=%h, required E21 a5 00",
                     first_done(), obs_dout[20], obs_dout[21]);
        end
    endtask

    task automatic test_start_while_busy();
        int busy_low;
        drive_op(1'b1, 8'h3C, 8'h96, 5, 1'b1, 23);
        mem[8'h3C] = 8'h96;
        busy_low = 0;
        for (int k = 0; k < 20; k++) if (obs_busy[k] !== 1'b1) busy_low++;
        n_checks++;
        if (tx_bits(16) !== 16'h963C || obs_miso[0] !== 1'b1 || obs_miso[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_frame: got %h, required 963c", tx_bits(16));
        end
        n_checks++;
        if (first_cs_high() != 18 || first_done() != 20 || busy_low != 0) begin
            n_fail++;
            $display("FAIL busy_start_timing: cs E%0d done E%0d busy-low %0d, required 18 20 0",
                     first_cs_high(), first_done(), busy_low);
        end
    endtask

    task automatic test_start_at_done();
        drive_op(1'b1, 8'h10, 8'h5A, 20, 1'b1, 23);
        mem[8'h10] = 8'h5A;
        n_checks++;
        if (first_done() != 20 || obs_busy[21] !== 1'b0 || obs_cs[21] !== 1'b1 || obs_busy[22] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_at_done: done E%0d busy E21=%b cs E21=%b, required 20 0 1",
                     first_done(), obs_busy[21], obs_cs[21]);
        end
    endtask

    task automatic test_read_back();
        drive_op(1'b0, 8'h3C, 8'h00, -1, 1'b1, 23);
        n_checks++;
        if (first_done() != 21 || obs_dout[21] !== 8'h96) begin
            n_fail++;
            $display("FAIL read_back: done E%0d dout %h, required E21 96", first_done(), obs_dout[21]);
        end
    endtask

`ifdef SPI_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        drive_op(1'b0, 8'h10, 8'h00, -1, 1'b0, 45);
        n_checks++;
        if (first_done() != 42 || obs_err[42] !== 1'b1 || obs_err[41] !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: done E%0d err E42=%b, required E42 1", first_done(), obs_err[42]);
        end
        n_checks++;
        if (obs_cs[42] !== 1'b1 || obs_dout[42] !== 8'h96 || obs_busy[42] !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state: cs=%b dout=%h busy=%b, required 1 96 0",
                     obs_cs[42], obs_dout[42], obs_busy[42]);
        end
    endtask
`endif

    task automatic test_reset_mid();
        drive_op(1'b1, 8'h77, 8'h11, -1, 1'b1, 8);
        rst = 1'b1;
        #1;
        n_checks++;
        if (cs !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: cs=%b busy=%b done=%b dout=%h, required 1 0 0 00", cs, busy, done, dout);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive_op(1'b1, 8'h21, 8'hC3, -1, 1'b1, 23);
        n_checks++;
        if (tx_bits(16) !== 16'hC321 || first_cs_high() != 18 || first_done() != 20 || obs_err[20] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_recover: frame %h cs E%0d done E%0d, required c321 18 20",
                     tx_bits(16), first_cs_high(), first_done());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1; start = 1'b0; wr = 1'b0; addr = 8'h00; din = 8'h00;
        mosi = 1'b0; ready = 1'b0; op_done = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_write();
        test_read();
        test_read_unwritten();
        test_start_while_busy();
        test_start_at_done();
        test_read_back();
`ifdef SPI_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
